// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: owns the data-memory port, waits out the read
// latency of loads and presents one write-back record per instruction.
//
// state   | meaning
// IDLE    | no record held
// LD_WAIT | load issued, waiting MEM_LAT edges for read data
// OUT     | write-back record valid on outputs
module mem_access_stage #(
  parameter int W_OPR   = 32,
  parameter int ADDR    = 16,
  parameter int W_RD    = 4,
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v_i,
  output logic             stall_o,
  input  logic [W_OPR-1:0] result_i,
  input  logic             wb_i,
  input  logic [W_RD-1:0]  wb_r_i,
  input  logic             ld_i,
  input  logic             st_i,
  input  logic [ADDR-1:0]  ldst_addr_i,
  input  logic [W_OPR-1:0] st_data_i,
  output logic [ADDR-1:0]  mem_addr_o,
  output logic             mem_write_o,
  output logic [W_OPR-1:0] mem_data_o,
  input  logic [W_OPR-1:0] mem_data_i,
  output logic             v_o,
  input  logic             stall_i,
  output logic             wb_o,
  output logic [W_RD-1:0]  wb_r_o,
  output logic [W_OPR-1:0] result_o
);

  typedef enum logic [1:0] {IDLE, LD_WAIT, OUT} state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic             r_ld_wb;
  logic             r_v;
  logic             r_wb;
  logic [W_RD-1:0]  r_wb_r;
  logic [W_OPR-1:0] r_result;
  logic [ADDR-1:0]  r_mem_addr;
  logic             r_mem_write;
  logic [W_OPR-1:0] r_mem_data;

  logic w_stall;
  logic w_accept;

  assign w_stall  = (r_state == LD_WAIT) || ((r_state == OUT) && stall_i);
  assign w_accept = v_i && !w_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ld_wb     <= 1'b0;
      r_v         <= 1'b0;
      r_wb        <= 1'b0;
      r_wb_r      <= '0;
      r_result    <= '0;
      r_mem_addr  <= '0;
      r_mem_write <= 1'b0;
      r_mem_data  <= '0;
    end else begin
      // write strobe is a single-cycle pulse, never held by a downstream stall
      r_mem_write <= 1'b0;
      case (r_state)
        LD_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_result <= mem_data_i;
            r_v      <= 1'b1;
            r_wb     <= r_ld_wb;
            r_state  <= OUT;
          end
        end
        default: begin
          if (w_accept) begin
            r_wb_r <= wb_r_i;
            if (ld_i) begin
              // ld+st together is treated as a load
              r_mem_addr <= ldst_addr_i;
              r_cnt      <= LAT;
              r_ld_wb    <= wb_i;
              r_v        <= 1'b0;
              r_wb       <= 1'b0;
              r_state    <= LD_WAIT;
            end else if (st_i) begin
              r_mem_addr  <= ldst_addr_i;
              r_mem_data  <= st_data_i;
              r_mem_write <= 1'b1;
              r_result    <= result_i;
              r_v         <= 1'b1;
              r_wb        <= 1'b0;
              r_state     <= OUT;
            end else begin
              r_result <= result_i;
              r_v      <= 1'b1;
              r_wb     <= wb_i;
              r_state  <= OUT;
            end
          end else if ((r_state == OUT) && !stall_i) begin
            r_v     <= 1'b0;
            r_wb    <= 1'b0;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign stall_o     = w_stall;
  assign v_o         = r_v;
  assign wb_o        = r_wb;
  assign wb_r_o      = r_wb_r;
  assign result_o    = r_result;
  assign mem_addr_o  = r_mem_addr;
  assign mem_write_o = r_mem_write;
  assign mem_data_o  = r_mem_data;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: two instances (read latency 1 and 3), each with
// its own data memory, checked every cycle against a record-level model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        v_i[2], stall_o[2], ld_i[2], st_i[2], wb_i[2];
  logic        mem_write_o[2], v_o[2], stall_i[2], wb_o[2];
  logic [31:0] result_i[2], st_data_i[2], mem_data_o[2], mem_data_i[2], result_o[2];
  logic [3:0]  wb_r_i[2], wb_r_o[2];
  logic [15:0] ldst_addr_i[2], mem_addr_o[2];

  mem_access_stage #(.W_OPR(32), .ADDR(16), .W_RD(4), .MEM_LAT(1)) u0 (
    .clk(clk), .reset(reset), .v_i(v_i[0]), .stall_o(stall_o[0]),
    .result_i(result_i[0]), .wb_i(wb_i[0]), .wb_r_i(wb_r_i[0]),
    .ld_i(ld_i[0]), .st_i(st_i[0]), .ldst_addr_i(ldst_addr_i[0]),
    .st_data_i(st_data_i[0]), .mem_addr_o(mem_addr_o[0]),
    .mem_write_o(mem_write_o[0]), .mem_data_o(mem_data_o[0]),
    .mem_data_i(mem_data_i[0]), .v_o(v_o[0]), .stall_i(stall_i[0]),
    .wb_o(wb_o[0]), .wb_r_o(wb_r_o[0]), .result_o(result_o[0]));

  mem_access_stage #(.W_OPR(32), .ADDR(16), .W_RD(4), .MEM_LAT(3)) u1 (
    .clk(clk), .reset(reset), .v_i(v_i[1]), .stall_o(stall_o[1]),
    .result_i(result_i[1]), .wb_i(wb_i[1]), .wb_r_i(wb_r_i[1]),
    .ld_i(ld_i[1]), .st_i(st_i[1]), .ldst_addr_i(ldst_addr_i[1]),
    .st_data_i(st_data_i[1]), .mem_addr_o(mem_addr_o[1]),
    .mem_write_o(mem_write_o[1]), .mem_data_o(mem_data_o[1]),
    .mem_data_i(mem_data_i[1]), .v_o(v_o[1]), .stall_i(stall_i[1]),
    .wb_o(wb_o[1]), .wb_r_o(wb_r_o[1]), .result_o(result_o[1]));

  always #5 clk = ~clk;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] init_val(input int j);
    return 32'hA5A5_0000 | 32'(j);
  endfunction

  // Data memories: synchronous write, read data only valid once the address
  // has been stable for MEM_LAT-1 cycles (garbage before that).
  logic [31:0] bank[2][64];
  logic [15:0] adl[2][2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int j = 0; j < 64; j++) bank[k][j] <= init_val(j);
      end else if (mem_write_o[k]) begin
        bank[k][mem_addr_o[k][5:0]] <= mem_data_o[k];
      end
      adl[k][0] <= mem_addr_o[k];
      adl[k][1] <= adl[k][0];
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      mem_data_i[k] = 32'hBAD0_BAD0;
      if (k == 0 || adl[k][1] == mem_addr_o[k])
        mem_data_i[k] = bank[k][mem_addr_o[k][5:0]];
    end
  end

  int pass_cnt = 0;
  int total = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s[dut%0d] t=%0t actual=%h required=%h", nm, k, $time, act, exp);
    else
      pass_cnt++;
  endtask

  // Record-level model: at most one instruction in flight, visible from its
  // ready edge until the first edge it sees without a downstream stall.
  int          now = 0;
  bit          armed = 0;
  bit          have[2], isst[2];
  int          ready[2], mw_edge[2];
  logic        exp_wb[2];
  logic [3:0]  exp_rd[2];
  logic [31:0] exp_res[2], exp_md[2];
  logic [15:0] exp_addr[2];
  logic [31:0] mmem[2][64];

  task automatic model_step(input int k);
    bit vis, stl;
    if (reset) begin
      have[k] = 0;
      mw_edge[k] = -1;
      for (int j = 0; j < 64; j++) mmem[k][j] = init_val(j);
      armed = 1;
      return;
    end
    vis = have[k] && ready[k] <= now - 1;
    stl = (have[k] && !vis) || (vis && stall_i[k]);
    if (vis && !stall_i[k]) have[k] = 0;
    if (v_i[k] && !stl) begin
      have[k]   = 1;
      isst[k]   = 0;
      exp_rd[k] = wb_r_i[k];
      if (ld_i[k]) begin
        ready[k]    = now + lat(k);
        exp_wb[k]   = wb_i[k];
        exp_res[k]  = mmem[k][ldst_addr_i[k][5:0]];
        exp_addr[k] = ldst_addr_i[k];
      end else if (st_i[k]) begin
        ready[k]    = now;
        isst[k]     = 1;
        exp_wb[k]   = 1'b0;
        exp_addr[k] = ldst_addr_i[k];
        exp_md[k]   = st_data_i[k];
        mw_edge[k]  = now;
        mmem[k][ldst_addr_i[k][5:0]] = st_data_i[k];
      end else begin
        ready[k]   = now;
        exp_wb[k]  = wb_i[k];
        exp_res[k] = result_i[k];
      end
    end
  endtask

  task automatic compare(input int k);
    bit vis, stl;
    vis = have[k] && ready[k] <= now;
    stl = (have[k] && !vis) || (vis && stall_i[k]);
    chk("v_o", k, 32'(v_o[k]), 32'(vis));
    chk("stall_o", k, 32'(stall_o[k]), 32'(stl));
    chk("mem_write_o", k, 32'(mem_write_o[k]), 32'(mw_edge[k] == now));
    chk("wb_o", k, 32'(wb_o[k]), vis ? 32'(exp_wb[k]) : 32'd0);
    if (vis) begin
      chk("wb_r_o", k, 32'(wb_r_o[k]), 32'(exp_rd[k]));
      if (!isst[k]) chk("result_o", k, result_o[k], exp_res[k]);
    end
    if ((have[k] && !vis) || mw_edge[k] == now)
      chk("mem_addr_o", k, 32'(mem_addr_o[k]), 32'(exp_addr[k]));
    if (mw_edge[k] == now)
      chk("mem_data_o", k, mem_data_o[k], exp_md[k]);
  endtask

  initial begin
    have = '{0, 0};
    mw_edge = '{-1, -1};
    forever begin
      @(posedge clk);
      now++;
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (armed)
        for (int k = 0; k < 2; k++) compare(k);
    end
  end

  task automatic send(input int k, input logic ld, input logic st, input logic wb,
                      input logic [3:0] rd, input logic [31:0] res,
                      input logic [15:0] addr, input logic [31:0] sd);
    bit ok;
    @(negedge clk);
    v_i[k] = 1'b1; ld_i[k] = ld; st_i[k] = st; wb_i[k] = wb;
    wb_r_i[k] = rd; result_i[k] = res; ldst_addr_i[k] = addr; st_data_i[k] = sd;
    #1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      ok = !stall_o[k];
      @(posedge clk);
      if (ok) break;
      @(negedge clk);
      #1;
    end
    chk("accept", k, 32'(ok), 32'd1);
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    v_i[k] = 1'b0; ld_i[k] = 1'b0; st_i[k] = 1'b0;
  endtask

  task automatic suite(input int k);
    int vc, mwc, sc;
    // reset held two cycles with a load outstanding
    send(k, 1, 0, 1, 4'd1, 32'd0, 16'h0004, 32'd0);
    @(negedge clk);
    v_i[k] = 1'b0; ld_i[k] = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    chk("rst_v_o", k, 32'(v_o[k]), 32'd0);
    chk("rst_wb_o", k, 32'(wb_o[k]), 32'd0);
    chk("rst_wb_r_o", k, 32'(wb_r_o[k]), 32'd0);
    chk("rst_result_o", k, result_o[k], 32'd0);
    chk("rst_mem_addr_o", k, 32'(mem_addr_o[k]), 32'd0);
    chk("rst_mem_write_o", k, 32'(mem_write_o[k]), 32'd0);
    chk("rst_mem_data_o", k, mem_data_o[k], 32'd0);
    chk("rst_stall_o", k, 32'(stall_o[k]), 32'd0);
    reset = 1'b0;
    vc = 0;
    repeat (6) begin
      @(negedge clk); #2;
      if (v_o[k]) vc++;
    end
    chk("rst_no_record", k, 32'(vc), 32'd0);

    // ALU op, one-cycle latency
    send(k, 0, 0, 1, 4'd3, 32'h0000_0007, 16'h0000, 32'd0);
    idle(k);
    #2;
    chk("add_v_o", k, 32'(v_o[k]), 32'd1);
    chk("add_wb_o", k, 32'(wb_o[k]), 32'd1);
    chk("add_wb_r_o", k, 32'(wb_r_o[k]), 32'd3);
    chk("add_result_o", k, result_o[k], 32'd7);
    chk("add_mem_write_o", k, 32'(mem_write_o[k]), 32'd0);
    idle(k);

    // store held by a three-cycle downstream stall
    stall_i[k] = 1'b1;
    send(k, 0, 1, 1, 4'd9, 32'h1111_1111, 16'h0005, 32'hDEAD_BEEF);
    vc = 0; mwc = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      v_i[k] = 1'b0; st_i[k] = 1'b0;
      if (i == 3) stall_i[k] = 1'b0;
      #2;
      if (v_o[k]) vc++;
      if (mem_write_o[k]) mwc++;
    end
    chk("st_v_cycles", k, 32'(vc), 32'd4);
    chk("st_write_cycles", k, 32'(mwc), 32'd1);
    chk("st_bank5", k, bank[k][5], 32'hDEAD_BEEF);

    // load r2 from the stored location
    send(k, 1, 0, 1, 4'd2, 32'd0, 16'h0005, 32'd0);
    sc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v_i[k] = 1'b0; ld_i[k] = 1'b0;
      #2;
      if (v_o[k]) break;
      if (stall_o[k]) sc++;
    end
    chk("ld_stall_cycles", k, 32'(sc), 32'(lat(k)));
    chk("ld_v_o", k, 32'(v_o[k]), 32'd1);
    chk("ld_result_o", k, result_o[k], 32'hDEAD_BEEF);
    chk("ld_wb_r_o", k, 32'(wb_r_o[k]), 32'd2);
    chk("ld_mem_addr_o", k, 32'(mem_addr_o[k]), 32'h0005);
    idle(k);

    // ld+st together behaves as a load of the initial word at 0x4
    send(k, 1, 1, 1, 4'd5, 32'd0, 16'h0004, 32'h5555_5555);
    idle(k);
    repeat (lat(k) + 1) idle(k);
    chk("ldst_bank4", k, bank[k][4], init_val(4));

    // five back-to-back ALU ops
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v_i[k] = 1'b1; ld_i[k] = 1'b0; st_i[k] = 1'b0; wb_i[k] = 1'b1;
      wb_r_i[k] = 4'(i + 1); result_i[k] = 32'(10 + i);
      #2;
      chk("b2b_stall_o", k, 32'(stall_o[k]), 32'd0);
      if (i > 0) begin
        chk("b2b_v_o", k, 32'(v_o[k]), 32'd1);
        chk("b2b_result_o", k, result_o[k], 32'(10 + i - 1));
      end
      @(posedge clk);
    end
    idle(k);
    #2;
    chk("b2b_last_v_o", k, 32'(v_o[k]), 32'd1);
    chk("b2b_last_result_o", k, result_o[k], 32'd14);
    repeat (3) idle(k);
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      v_i[k] = 1'b0; ld_i[k] = 1'b0; st_i[k] = 1'b0; wb_i[k] = 1'b0;
      wb_r_i[k] = '0; result_i[k] = '0; ldst_addr_i[k] = '0;
      st_data_i[k] = '0; stall_i[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    suite(0);
    suite(1);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1);
  end

endmodule
